// File: rtl/cosim_sched_pkg.sv
// Shared types and widths for the co-simulation commit scheduler.
package cosim_sched_pkg;

  localparam int unsigned HART_ID_W = 4;
  localparam int unsigned PC_W      = 64;
  localparam int unsigned INSN_W    = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    HALTED   = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } commit_entry_t;

endpackage

// File: rtl/cosim_commit_fifo.sv
// Per-hart commit buffer; registered full/empty flags, head read from storage.
module cosim_commit_fifo
  import cosim_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  commit_entry_t din,
  input  logic          pop,
  output commit_entry_t head,
  output logic          full,
  output logic          empty,
  output logic          full_next_c
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  commit_entry_t    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  assign full_next_c = (count_next == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= full_next_c;
      empty <= (count_next == '0);
    end
  end

  // Storage is not reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cosim_commit_scheduler.sv
// Serialises per-hart retirement events into one ordered stream of step requests
// for a single-threaded reference model, halting on mismatch or response timeout.
module cosim_commit_scheduler
  import cosim_sched_pkg::*;
#(
  parameter int unsigned NUM_HARTS        = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter bit          HALT_ON_MISMATCH = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_HARTS-1:0]        commit_valid,
  output logic [NUM_HARTS-1:0]        commit_ready,
  input  logic [NUM_HARTS*PC_W-1:0]   commit_pc,
  input  logic [NUM_HARTS*INSN_W-1:0] commit_insn,
  output logic                        step_req_valid,
  input  logic                        step_req_ready,
  output logic [HART_ID_W-1:0]        step_req_hart,
  output logic [PC_W-1:0]             step_req_pc,
  output logic [INSN_W-1:0]           step_req_insn,
  input  logic                        step_rsp_valid,
  input  logic                        step_rsp_mismatch,
  output logic                        halted,
  output logic                        timeout_err,
  output logic [31:0]                 mismatch_cnt,
  output logic [63:0]                 checked_cnt
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_HARTS-1:0] fifo_push;
  logic [NUM_HARTS-1:0] fifo_pop;
  logic [NUM_HARTS-1:0] fifo_full;
  logic [NUM_HARTS-1:0] fifo_empty;
  logic [NUM_HARTS-1:0] fifo_full_next;
  logic [NUM_HARTS-1:0] req;
  commit_entry_t        fifo_din  [NUM_HARTS];
  commit_entry_t        fifo_head [NUM_HARTS];
  commit_entry_t        head_sel;

  state_t               state_q, state_next;
  logic [HART_ID_W-1:0] rr_ptr_q, rr_ptr_next;
  logic [TIMER_W-1:0]   timer_q, timer_next;
  logic [HART_ID_W-1:0] grant, grant_lo, grant_hi;
  logic                 grant_valid, found_hi;
  logic                 load_req, rsp_fire, timeout_fire;

  // Halted blocks all pushes; equivalent to commit_valid & commit_ready.
  assign fifo_push = commit_valid & ~fifo_full & {NUM_HARTS{state_q != HALTED}};
  assign req       = ~fifo_empty;

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_fifo
    assign fifo_din[i] = '{pc: commit_pc[PC_W*i +: PC_W], insn: commit_insn[INSN_W*i +: INSN_W]};

    cosim_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_push[i]),
      .din        (fifo_din[i]),
      .pop        (fifo_pop[i]),
      .head       (fifo_head[i]),
      .full       (fifo_full[i]),
      .empty      (fifo_empty[i]),
      .full_next_c(fifo_full_next[i])
    );
  end

  // Round-robin: lowest requester at/above the pointer, else lowest overall (wrap).
  always_comb begin
    grant_lo    = '0;
    grant_hi    = '0;
    grant_valid = 1'b0;
    found_hi    = 1'b0;
    for (int k = int'(NUM_HARTS) - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_lo    = HART_ID_W'(k);
        grant_valid = 1'b1;
        if (HART_ID_W'(k) >= rr_ptr_q) begin
          grant_hi = HART_ID_W'(k);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    head_sel = fifo_head[0];
    for (int k = 0; k < int'(NUM_HARTS); k++) begin
      if (grant == HART_ID_W'(k)) head_sel = fifo_head[k];
    end
  end

  always_comb begin
    state_next   = state_q;
    rr_ptr_next  = rr_ptr_q;
    timer_next   = timer_q;
    load_req     = 1'b0;
    rsp_fire     = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load_req    = 1'b1;
          rr_ptr_next = (grant == HART_ID_W'(NUM_HARTS - 1)) ? '0 : grant + HART_ID_W'(1);
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (step_req_ready) begin
          timer_next = '0;
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the same cycle as the timeout takes priority.
        if (step_rsp_valid) begin
          rsp_fire   = 1'b1;
          state_next = (step_rsp_mismatch && HALT_ON_MISMATCH) ? HALTED : IDLE;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_fire = 1'b1;
          state_next   = HALTED;
        end else begin
          timer_next = timer_q + TIMER_W'(1);
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = '0;
    for (int k = 0; k < int'(NUM_HARTS); k++) begin
      fifo_pop[k] = load_req && (grant == HART_ID_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_next;
      rr_ptr_q <= rr_ptr_next;
      timer_q  <= timer_next;
    end
  end

  // Registered outputs follow the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_ready   <= '1;
      step_req_valid <= 1'b0;
      step_req_hart  <= '0;
      step_req_pc    <= '0;
      step_req_insn  <= '0;
      halted         <= 1'b0;
      timeout_err    <= 1'b0;
      mismatch_cnt   <= '0;
      checked_cnt    <= '0;
    end else begin
      commit_ready   <= ~fifo_full_next & {NUM_HARTS{state_next != HALTED}};
      step_req_valid <= (state_next == ISSUE);
      halted         <= (state_next == HALTED);
      if (load_req) begin
        step_req_hart <= grant;
        step_req_pc   <= head_sel.pc;
        step_req_insn <= head_sel.insn;
      end
      if (rsp_fire) begin
        checked_cnt <= checked_cnt + 64'd1;
        if (step_rsp_mismatch && (mismatch_cnt != 32'hFFFF_FFFF)) begin
          mismatch_cnt <= mismatch_cnt + 32'd1;
        end
      end
      if (timeout_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cosim_commit_scheduler.sv
// Directed bench: one halting scheduler (timeout 16) and one that keeps running on mismatch.
module tb_cosim_commit_scheduler;

  logic          clk = 1'b0;
  logic          rst_n;

  logic [3:0]    commit_valid;
  logic [3:0]    commit_ready;
  logic [255:0]  commit_pc;
  logic [127:0]  commit_insn;
  logic          step_req_valid, step_req_ready;
  logic [3:0]    step_req_hart;
  logic [63:0]   step_req_pc;
  logic [31:0]   step_req_insn;
  logic          step_rsp_valid, step_rsp_mismatch;
  logic          halted, timeout_err;
  logic [31:0]   mismatch_cnt;
  logic [63:0]   checked_cnt;

  logic [3:0]    c_commit_valid;
  logic [3:0]    c_commit_ready;
  logic [255:0]  c_commit_pc;
  logic [127:0]  c_commit_insn;
  logic          c_step_req_valid, c_step_req_ready;
  logic [3:0]    c_step_req_hart;
  logic [63:0]   c_step_req_pc;
  logic [31:0]   c_step_req_insn;
  logic          c_step_rsp_valid, c_step_rsp_mismatch;
  logic          c_halted, c_timeout_err;
  logic [31:0]   c_mismatch_cnt;
  logic [63:0]   c_checked_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cosim_commit_scheduler #(
    .NUM_HARTS(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .HALT_ON_MISMATCH(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_insn(commit_insn),
    .step_req_valid(step_req_valid), .step_req_ready(step_req_ready),
    .step_req_hart(step_req_hart), .step_req_pc(step_req_pc), .step_req_insn(step_req_insn),
    .step_rsp_valid(step_rsp_valid), .step_rsp_mismatch(step_rsp_mismatch),
    .halted(halted), .timeout_err(timeout_err),
    .mismatch_cnt(mismatch_cnt), .checked_cnt(checked_cnt)
  );

  cosim_commit_scheduler #(
    .NUM_HARTS(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .HALT_ON_MISMATCH(1'b0)
  ) u_cont (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(c_commit_valid), .commit_ready(c_commit_ready),
    .commit_pc(c_commit_pc), .commit_insn(c_commit_insn),
    .step_req_valid(c_step_req_valid), .step_req_ready(c_step_req_ready),
    .step_req_hart(c_step_req_hart), .step_req_pc(c_step_req_pc), .step_req_insn(c_step_req_insn),
    .step_rsp_valid(c_step_rsp_valid), .step_rsp_mismatch(c_step_rsp_mismatch),
    .halted(c_halted), .timeout_err(c_timeout_err),
    .mismatch_cnt(c_mismatch_cnt), .checked_cnt(c_checked_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic push(input int hart, input logic [63:0] pc, input logic [31:0] insn);
    commit_valid = 4'b0001 << hart;
    commit_pc[64*hart +: 64]   = pc;
    commit_insn[32*hart +: 32] = insn;
    step();
    commit_valid = '0;
  endtask

  // Waits (bounded) for a request, checks its fields, accepts it and responds.
  task automatic serve(input int hart, input logic [63:0] pc, input logic [31:0] insn,
                       input logic mism, input int delay);
    int c;
    c = 0;
    while (!step_req_valid && c < 50) begin
      step();
      c++;
    end
    check_eq("req_valid", 64'(step_req_valid), 64'd1);
    check_eq("req_hart",  64'(step_req_hart), 64'(hart));
    check_eq("req_pc",    step_req_pc, pc);
    check_eq("req_insn",  64'(step_req_insn), 64'(insn));
    step_req_ready = 1'b1;
    step();
    step_req_ready = 1'b0;
    repeat (delay) step();
    step_rsp_valid    = 1'b1;
    step_rsp_mismatch = mism;
    step();
    step_rsp_valid    = 1'b0;
    step_rsp_mismatch = 1'b0;
  endtask

  task automatic c_serve(input logic [63:0] pc, input logic mism);
    int c;
    c = 0;
    while (!c_step_req_valid && c < 50) begin
      step();
      c++;
    end
    check_eq("c_req_valid", 64'(c_step_req_valid), 64'd1);
    check_eq("c_req_pc", c_step_req_pc, pc);
    c_step_req_ready = 1'b1;
    step();
    c_step_req_ready = 1'b0;
    c_step_rsp_valid    = 1'b1;
    c_step_rsp_mismatch = mism;
    step();
    c_step_rsp_valid    = 1'b0;
    c_step_rsp_mismatch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_pc [5];
    int c;
    rst_n = 1'b0;
    commit_valid = '0; commit_pc = '0; commit_insn = '0;
    step_req_ready = 1'b0; step_rsp_valid = 1'b0; step_rsp_mismatch = 1'b0;
    c_commit_valid = '0; c_commit_pc = '0; c_commit_insn = '0;
    c_step_req_ready = 1'b0; c_step_rsp_valid = 1'b0; c_step_rsp_mismatch = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset values
    check_eq("rst_ready",    64'(commit_ready), 64'hF);
    check_eq("rst_valid",    64'(step_req_valid), 64'd0);
    check_eq("rst_halted",   64'(halted), 64'd0);
    check_eq("rst_timeout",  64'(timeout_err), 64'd0);
    check_eq("rst_mismatch", 64'(mismatch_cnt), 64'd0);
    check_eq("rst_checked",  checked_cnt, 64'd0);

    // Single commit: request visible after T+1, response three cycles after accept
    push(0, 64'h8000_0000, 32'h0000_0013);
    check_eq("lat_T", 64'(step_req_valid), 64'd0);
    step();
    check_eq("lat_T1", 64'(step_req_valid), 64'd1);
    serve(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 2);
    check_eq("single_checked", checked_cnt, 64'd1);
    check_eq("single_halted", 64'(halted), 64'd0);
    check_eq("single_idle_valid", 64'(step_req_valid), 64'd0);

    // Four harts at once, pointer at 0; extra hart-1 commit served after hart 3
    do_reset();
    commit_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      commit_pc[64*i +: 64]   = 64'h1000 + 64'(4 * i);
      commit_insn[32*i +: 32] = 32'h1000_0000 | 32'(i);
    end
    step();
    commit_valid = '0;
    serve(0, 64'h1000, 32'h1000_0000, 1'b0, 0);
    push(1, 64'h2000, 32'h2000_0001);
    check_eq("pushpop_ready", 64'(commit_ready), 64'hF);
    serve(1, 64'h1004, 32'h1000_0001, 1'b0, 0);
    serve(2, 64'h1008, 32'h1000_0002, 1'b0, 0);
    serve(3, 64'h100C, 32'h1000_0003, 1'b0, 0);
    serve(1, 64'h2000, 32'h2000_0001, 1'b0, 0);
    check_eq("rr_checked", checked_cnt, 64'd5);

    // Hart 2 fills its FIFO while hart 0's request is stalled
    do_reset();
    push(0, 64'h3000, 32'h0000_3000);
    step();
    check_eq("stall_req", 64'(step_req_valid), 64'd1);
    for (int k = 0; k < 5; k++) a_pc[k] = 64'hA000 + 64'(8 * k);
    for (int k = 0; k < 4; k++) begin
      commit_valid = 4'b0100;
      commit_pc[128 +: 64] = a_pc[k];
      commit_insn[64 +: 32] = 32'hA0 + 32'(k);
      check_eq("fill_ready", 64'(commit_ready[2]), 64'd1);
      step();
    end
    commit_pc[128 +: 64] = a_pc[4];
    commit_insn[64 +: 32] = 32'hA4;
    check_eq("full_ready", 64'(commit_ready[2]), 64'd0);
    step();
    step();
    check_eq("full_held", 64'(commit_ready[2]), 64'd0);
    serve(0, 64'h3000, 32'h0000_3000, 1'b0, 0);
    check_eq("full_after_rsp", 64'(commit_ready[2]), 64'd0);
    step();
    check_eq("ready_after_pop", 64'(commit_ready[2]), 64'd1);
    step();
    commit_valid = '0;
    check_eq("refull_ready", 64'(commit_ready[2]), 64'd0);
    for (int k = 0; k < 5; k++) serve(2, a_pc[k], 32'hA0 + 32'(k), 1'b0, 0);

    // Mismatch halts; reset recovers
    do_reset();
    push(3, 64'h4000, 32'h0000_4000);
    serve(3, 64'h4000, 32'h0000_4000, 1'b1, 1);
    check_eq("mm_cnt",     64'(mismatch_cnt), 64'd1);
    check_eq("mm_checked", checked_cnt, 64'd1);
    check_eq("mm_halted",  64'(halted), 64'd1);
    check_eq("mm_ready",   64'(commit_ready), 64'd0);
    push(0, 64'h4100, 32'h0000_4100);
    step();
    check_eq("mm_no_req",   64'(step_req_valid), 64'd0);
    check_eq("mm_still_halted", 64'(halted), 64'd1);
    do_reset();
    check_eq("rec_halted",   64'(halted), 64'd0);
    check_eq("rec_mismatch", 64'(mismatch_cnt), 64'd0);
    check_eq("rec_checked",  checked_cnt, 64'd0);
    check_eq("rec_ready",    64'(commit_ready), 64'hF);

    // Timeout: halted exactly 16 edges after acceptance
    push(1, 64'h5000, 32'h0000_5000);
    c = 0;
    while (!step_req_valid && c < 50) begin
      step();
      c++;
    end
    check_eq("to_req", 64'(step_req_valid), 64'd1);
    step_req_ready = 1'b1;
    step();
    step_req_ready = 1'b0;
    repeat (15) step();
    check_eq("to_early_halted",  64'(halted), 64'd0);
    check_eq("to_early_timeout", 64'(timeout_err), 64'd0);
    step();
    check_eq("to_halted",  64'(halted), 64'd1);
    check_eq("to_timeout", 64'(timeout_err), 64'd1);
    check_eq("to_ready",   64'(commit_ready), 64'd0);

    // Non-halting instance: three mismatches keep running
    for (int k = 0; k < 3; k++) begin
      c_commit_valid = 4'b0001;
      c_commit_pc[63:0] = 64'h6000 + 64'(4 * k);
      step();
    end
    c_commit_valid = '0;
    for (int k = 0; k < 3; k++) c_serve(64'h6000 + 64'(4 * k), 1'b1);
    check_eq("c_mismatch", 64'(c_mismatch_cnt), 64'd3);
    check_eq("c_checked",  c_checked_cnt, 64'd3);
    check_eq("c_halted",   64'(c_halted), 64'd0);
    check_eq("c_ready",    64'(c_commit_ready), 64'hF);

    // Stray response while idle is ignored
    step();
    c_step_rsp_valid = 1'b1;
    c_step_rsp_mismatch = 1'b1;
    step();
    c_step_rsp_valid = 1'b0;
    c_step_rsp_mismatch = 1'b0;
    check_eq("c_stray_checked",  c_checked_cnt, 64'd3);
    check_eq("c_stray_mismatch", 64'(c_mismatch_cnt), 64'd3);

    // Response on the timeout cycle wins
    c_commit_valid = 4'b0001;
    c_commit_pc[63:0] = 64'h7000;
    step();
    c_commit_valid = '0;
    c = 0;
    while (!c_step_req_valid && c < 50) begin
      step();
      c++;
    end
    check_eq("c_race_req", 64'(c_step_req_valid), 64'd1);
    c_step_req_ready = 1'b1;
    step();
    c_step_req_ready = 1'b0;
    repeat (15) step();
    c_step_rsp_valid = 1'b1;
    step();
    c_step_rsp_valid = 1'b0;
    check_eq("c_race_halted",  64'(c_halted), 64'd0);
    check_eq("c_race_timeout", 64'(c_timeout_err), 64'd0);
    check_eq("c_race_checked", c_checked_cnt, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cosim_commit_scheduler.md
Name: cosim_commit_scheduler

Overview:
- Serialises retirement events from NUM_HARTS cores into a single ordered stream of Spike step requests.
- The Spike DPI model is single-threaded, so only one hart may be stepped or compared at a time.
- Sits between the per-tile commit monitors and the DPI-calling checker.
- Buffers commits per hart, arbitrates round-robin, tracks the one outstanding step, and halts on mismatch or timeout.

Parameters:
- NUM_HARTS, 4, number of harts feeding commits (1..16).
- FIFO_DEPTH, 4, commit entries buffered per hart (power of 2, ≥2).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for a checker response.
- HALT_ON_MISMATCH, 1, 1 = enter HALTED on the first mismatch; 0 = count it and continue.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- commit_valid  in  NUM_HARTS  per-hart retire strobe.
- commit_ready  out  NUM_HARTS  per-hart FIFO-not-full (and not halted).
- commit_pc  in  NUM_HARTS*64  per-hart retired PC; hart i at bits [64i+63:64i].
- commit_insn  in  NUM_HARTS*32  per-hart retired instruction word.
- step_req_valid  out  1  step request to the checker.
- step_req_ready  in  1  checker accepts the request.
- step_req_hart  out  4  hart id to step.
- step_req_pc  out  64  expected PC.
- step_req_insn  out  32  expected instruction.
- step_rsp_valid  in  1  checker finished the step and compare.
- step_rsp_mismatch  in  1  compare failed; qualified by step_rsp_valid.
- halted  out  1  scheduler stopped.
- timeout_err  out  1  sticky: no response within TIMEOUT_CYCLES.
- mismatch_cnt  out  32  saturating mismatch count.
- checked_cnt  out  64  count of completed steps (responses received).

Behaviour:
- Reset:
  - Synchronous, active-low: reset is sampled on the clk edge.
  - FIFOs are empty, state is IDLE, and the round-robin pointer is 0.
  - All outputs reset to 0, except commit_ready = all ones.
  - Reset asserted mid-operation (in any state) drops any outstanding request and takes effect at the next edge.
- Enqueue:
  - A hart pushes on commit_valid && commit_ready.
  - commit_ready[i] = !full[i] && !halted.
  - A simultaneous push and pop on the same FIFO leaves its count unchanged.
  - commit_valid while not ready is ignored; no entry is written.
- Arbitration:
  - The request vector is the per-hart non-empty flags.
  - The grant goes to the first requester at or after the pointer, searching upward and wrapping at NUM_HARTS-1 → 0.
  - On a grant, the pointer becomes grant+1 mod NUM_HARTS.
- FSM IDLE:
  - If any FIFO is non-empty: pop the granted head, latch hart, pc and insn into the request registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- FSM ISSUE:
  - step_req_valid = 1 and request fields are held stable until step_req_ready.
  - On step_req_ready: clear the timer and go to WAIT_RSP.
- FSM WAIT_RSP:
  - step_req_valid = 0 and the timer increments every cycle.
  - On step_rsp_valid: checked_cnt increments.
  - If mismatch, mismatch_cnt increments, saturating at 0xFFFFFFFF.
  - Next state is HALTED if (mismatch && HALT_ON_MISMATCH), otherwise IDLE.
  - If the timer reaches TIMEOUT_CYCLES-1 without a response: set timeout_err and go to HALTED.
  - If the response arrives in the same cycle the timeout would fire, the response wins.
- FSM HALTED:
  - Terminal until reset.
  - halted = 1, commit_ready = 0, step_req_valid = 0.
  - FIFO contents are retained for debug.
- Latency:
  - A commit accepted at edge T into an empty scheduler produces step_req_valid after edge T+1.
  - The next step_req_valid follows no earlier than one IDLE cycle after the response.
- Ordering:
  - Each hart's commits are issued in program order.
  - Only one step is outstanding at a time.
  - step_rsp_valid outside WAIT_RSP is ignored.

Decomposition:
- cosim_sched_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT_RSP, HALTED};
  - the commit_entry_t struct {pc 64, insn 32};
  - HART_ID_W = 4.
- Sub-module cosim_commit_fifo:
  - parameterised depth;
  - outputs full, empty and head;
  - supports simultaneous push and pop;
  - instantiated NUM_HARTS times.

Test Plan:
- Single hart 0 commits pc=0x80000000, insn=0x00000013; checker readies immediately and responds with mismatch=0 three cycles later → step_req_valid after T+1 with hart=0 and matching fields; checked_cnt=1, state returns to IDLE.
- All 4 harts commit in the same cycle with the pointer at 0 → requests issued in hart order 0,1,2,3; a further commit on hart 1 is served after hart 3.
- Hart 2 pushes 5 commits back-to-back with FIFO_DEPTH=4 and the checker stalled → commit_ready[2]=0 after the 4th; the 5th is held and accepted after the first pop; PCs are issued in order.
- Response with mismatch=1 and HALT_ON_MISMATCH=1 → mismatch_cnt=1, halted=1 next cycle, all commit_ready=0; rst_n low for one edge restores IDLE with all counters at 0.
- step_req_ready=1 with no response and TIMEOUT_CYCLES=16 → timeout_err=1 and halted=1 exactly 16 cycles after the acceptance edge.
- HALT_ON_MISMATCH=0 with three mismatching responses → mismatch_cnt=3, checked_cnt=3, scheduler not halted.
